// File: rtl/nes_bus_pkg.sv
// Shared CPU/memory bus definitions: DMA trigger and OAM data port addresses,
// plus the sprite-DMA engine state encoding.
package nes_bus_pkg;

   localparam logic [15:0] OAM_DMA_ADDR = 16'h4014;
   localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HALT  = 3'd1,
      ALIGN = 3'd2,
      READ  = 3'd3,
      WRITE = 3'd4
   } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// Sprite-DMA engine between the CPU address/data outputs and the memory bus.
// Passes CPU cycles through when idle; a write to $4014 halts the CPU and
// copies page {data,00..FF} to OAMDATA ($2004), reads aligned to par=0.
// Ports:
//   clk, reset         - clock, asynchronous active-high reset
//   cpu_addr/wdata/we  - CPU bus cycle request
//   mem_rdata          - memory read data (combinational w.r.t. bus_addr)
//   bus_addr/wdata/we  - bus cycle driven to memory
//   cpu_rdy            - high when the CPU may advance
//   dma_active         - high while the engine owns the bus
module oam_dma
   import nes_bus_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_we,
   input  logic [7:0]  mem_rdata,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_wdata,
   output logic        bus_we,
   output logic        cpu_rdy,
   output logic        dma_active
);

   dma_state_t state_q, state_d;
   logic [7:0] page_q, page_d;
   logic [7:0] idx_q, idx_d;
   logic [7:0] buf_q, buf_d;
   logic       par_q, par_d;

   // Next-state and datapath updates
   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      idx_d   = idx_q;
      buf_d   = buf_q;
      par_d   = ~par_q;
      case (state_q)
         IDLE: begin
            if (cpu_we && (cpu_addr == OAM_DMA_ADDR)) begin
               page_d  = cpu_wdata;
               idx_d   = 8'd0;
               state_d = HALT;
            end
         end
         // Skip ALIGN when the following cycle is already a get cycle
         HALT:    state_d = par_q ? READ : ALIGN;
         ALIGN:   state_d = READ;
         READ: begin
            buf_d   = mem_rdata;
            state_d = WRITE;
         end
         WRITE: begin
            idx_d   = idx_q + 8'd1;
            state_d = (idx_q == 8'hFF) ? IDLE : READ;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         page_q  <= 8'd0;
         idx_q   <= 8'd0;
         buf_q   <= 8'd0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         page_q  <= page_d;
         idx_q   <= idx_d;
         buf_q   <= buf_d;
         par_q   <= par_d;
      end
   end

   // Bus mux: passthrough, source page read, or OAMDATA write
   always_comb begin
      bus_addr   = cpu_addr;
      bus_wdata  = buf_q;
      bus_we     = 1'b0;
      cpu_rdy    = 1'b0;
      dma_active = 1'b0;
      case (state_q)
         IDLE: begin
            bus_wdata = cpu_wdata;
            bus_we    = cpu_we;
            cpu_rdy   = 1'b1;
         end
         HALT: ;
         ALIGN:   dma_active = 1'b1;
         READ: begin
            bus_addr   = {page_q, idx_q};
            dma_active = 1'b1;
         end
         WRITE: begin
            bus_addr   = OAMDATA_ADDR;
            bus_we     = 1'b1;
            dma_active = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_oam_dma.sv
// Randomized scoreboard bench for oam_dma: a memory model feeds mem_rdata,
// each trigger queues the expected 256 (read address, data) pairs and the
// expected stall length; a negedge monitor pops and compares.
module tb_oam_dma;
   import nes_bus_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_we;
   logic [7:0]  mem_rdata;
   logic [15:0] bus_addr;
   logic [7:0]  bus_wdata;
   logic        bus_we;
   logic        cpu_rdy;
   logic        dma_active;

   logic [7:0] mem [0:65535];

   typedef struct {
      logic [15:0] raddr;
      logic [7:0]  data;
   } exp_t;

   exp_t exp_q[$];
   int   stall_q[$];

   int n_vec = 0;
   int n_err = 0;
   int tb_cyc;

   int          stall_len = 0;
   logic [15:0] prev_addr = 16'h0;
   bit          prev_par  = 1'b0;

   oam_dma dut (
      .clk(clk), .reset(reset),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
      .mem_rdata(mem_rdata),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
      .cpu_rdy(cpu_rdy), .dma_active(dma_active)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[bus_addr];

   // Bench-side cycle count since reset; bit 0 is the parity of the current cycle
   always @(posedge clk or posedge reset) begin
      if (reset) tb_cyc <= 0;
      else       tb_cyc <= tb_cyc + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: DMA writes against the expected queue, stall lengths against stall_q
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         stall_len = 0;
         prev_addr = 16'h0;
         prev_par  = 1'b0;
      end else begin
         if (dma_active && bus_we) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_dma_write", 32'(bus_addr), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("oam_addr",  32'(bus_addr),  32'(OAMDATA_ADDR));
               chk("oam_data",  32'(bus_wdata), 32'(e.data));
               chk("read_addr", 32'(prev_addr), 32'(e.raddr));
               chk("read_par",  32'(prev_par),  32'd0);
            end
         end
         if (!cpu_rdy) begin
            stall_len++;
         end else if (stall_len != 0) begin
            if (stall_q.size() == 0) chk("unexpected_stall", 32'(stall_len), 32'd0);
            else                     chk("stall_len", 32'(stall_len), 32'(stall_q.pop_front()));
            stall_len = 0;
         end
         prev_addr = bus_addr;
         prev_par  = tb_cyc[0];
      end
   end

   // One idle CPU cycle, checked for passthrough; entered and left at posedge+1
   task automatic pass_cycle(input logic [15:0] a, input logic [7:0] d, input logic we);
      cpu_addr = a; cpu_wdata = d; cpu_we = we;
      @(negedge clk);
      chk("pass_addr",   32'(bus_addr),   32'(a));
      chk("pass_we",     32'(bus_we),     32'(we));
      if (we) chk("pass_wdata", 32'(bus_wdata), 32'(d));
      chk("pass_rdy",    32'(cpu_rdy),    32'd1);
      chk("pass_active", 32'(dma_active), 32'd0);
      @(posedge clk); #1;
   endtask

   // Write $4014 on a cycle with the requested parity and queue the expected copy
   task automatic trigger(input logic [7:0] pg, input bit p);
      exp_t e;
      cpu_we = 1'b0;
      if (tb_cyc[0] != p) begin @(posedge clk); #1; end
      for (int i = 0; i < 256; i++) begin
         e.raddr = {pg, 8'(i)};
         e.data  = mem[{pg, 8'(i)}];
         exp_q.push_back(e);
      end
      stall_q.push_back(513 + int'(p));
      pass_cycle(OAM_DMA_ADDR, pg, 1'b1);
      cpu_we = 1'b0; cpu_addr = 16'h1234; cpu_wdata = 8'h00;
   endtask

   // Bounded wait for the engine to hand the bus back
   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 1100 && !done; i++) begin
         @(negedge clk);
         if (cpu_rdy) done = 1'b1;
      end
      #1;
      chk("dma_done",        32'(done),           32'd1);
      chk("all_bytes_moved", 32'(exp_q.size()),   32'd0);
      chk("stall_seen",      32'(stall_q.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          found;
      logic [15:0] a;
      logic        we;
      logic [7:0]  pg;

      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;
      mem[16'h0123] = 8'h5A;

      reset = 1'b1; cpu_addr = 16'h0ABC; cpu_wdata = 8'h11; cpu_we = 1'b0;
      #3;
      chk("rst_rdy",    32'(cpu_rdy),    32'd1);
      chk("rst_active", 32'(dma_active), 32'd0);
      chk("rst_addr",   32'(bus_addr),   32'h0ABC);
      chk("rst_we",     32'(bus_we),     32'd0);
      @(negedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;

      // Plain CPU read, then random passthrough traffic
      pass_cycle(16'h0123, 8'h00, 1'b0);
      for (int k = 0; k < 20; k++) begin
         a  = 16'($urandom);
         we = 1'($urandom);
         if (we && a == OAM_DMA_ADDR) a = 16'h4015;
         pass_cycle(a, 8'($urandom), we);
      end

      // Page $02 on both trigger parities
      trigger(8'h02, 1'b0);
      wait_idle();
      pass_cycle(16'h0123, 8'h00, 1'b0);
      trigger(8'h02, 1'b1);
      wait_idle();

      // Top page: reads end at $FFFF, nothing beyond
      trigger(8'hFF, 1'($urandom));
      wait_idle();
      pass_cycle(16'h0000, 8'h00, 1'b0);

      // Reset in the READ of idx $40
      trigger(8'h07, 1'($urandom));
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         @(negedge clk);
         if (dma_active && !bus_we && bus_addr == 16'h0740) found = 1'b1;
      end
      chk("read40_reached", 32'(found), 32'd1);
      #1 reset = 1'b1;
      exp_q.delete();
      stall_q.delete();
      #1;
      chk("midrst_rdy",    32'(cpu_rdy),    32'd1);
      chk("midrst_active", 32'(dma_active), 32'd0);
      chk("midrst_addr",   32'(bus_addr),   32'(cpu_addr));
      @(negedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;
      pass_cycle(16'h0456, 8'h00, 1'b0);
      trigger(8'h05, 1'($urandom));
      wait_idle();

      // $4014 writes held during the transfer must not retarget it
      trigger(8'h03, 1'($urandom));
      repeat (10) @(posedge clk);
      #1 cpu_addr = OAM_DMA_ADDR; cpu_wdata = 8'h77; cpu_we = 1'b1;
      repeat (50) @(posedge clk);
      #1 cpu_addr = 16'h1234; cpu_we = 1'b0;
      wait_idle();

      // Random pages and parities
      for (int k = 0; k < 3; k++) begin
         pg = 8'($urandom);
         pass_cycle(16'($urandom), 8'h00, 1'b0);
         trigger(pg, 1'($urandom));
         wait_idle();
      end
      pass_cycle(16'h0123, 8'h00, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
